// File: rtl/sprite_pixel_gen.sv
// Sprite renderer: maps the LCD scan position onto a scaled, animated,
// palette-indexed sprite held in an external synchronous ROM. It produces
// one colour and a coverage flag per pixel, three cycles after the scan
// coordinate, and moves/animates the sprite once per LCD frame.
module sprite_pixel_gen #(
    parameter int X_MAX      = 800,
    parameter int Y_MAX      = 480,
    parameter int FIG_X0     = 730,
    parameter int FIG_Y0     = 220,
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 20,
    parameter int SCALE_LOG2 = 1,
    parameter int NUM_FRAMES = 2,
    parameter int MOVE_DIV   = 4,
    parameter int ANIM_DIV   = 16,
    parameter int STEP       = 1,
    parameter int ROM_AW     = 11,
    localparam int AFW       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [11:0]       lcd_xpos,
    input  logic [11:0]       lcd_ypos,
    input  logic              enable,
    input  logic              freeze,
    input  logic [1:0]        mov_x,
    input  logic [1:0]        mov_y,
    input  logic              pal_we,
    input  logic [3:0]        pal_addr,
    input  logic [23:0]       pal_wdata,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [23:0]       sprite_pixel,
    output logic              pixel_valid,
    output logic [11:0]       pos_x,
    output logic [11:0]       pos_y,
    output logic [AFW-1:0]    anim_frame
);

    // On-screen footprint of the scaled sprite and the furthest top-left
    // position that still keeps the whole box on screen.
    localparam int BOX_W        = SPR_W << SCALE_LOG2;
    localparam int BOX_H        = SPR_H << SCALE_LOG2;
    localparam int X_LIM        = X_MAX - BOX_W;
    localparam int Y_LIM        = Y_MAX - BOX_H;
    localparam int FRAME_TEXELS = SPR_W * SPR_H;
    localparam int MCW          = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int ACW          = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic signed [12:0] dx, dy;
    logic [11:0]        tx, ty;
    logic               inside_c;
    logic [31:0]        addr_c;
    logic               inside_s1, inside_s2;
    logic               at_origin, origin_q, frame_tick;
    logic [MCW-1:0]     move_cnt;
    logic [ACW-1:0]     anim_cnt;
    logic [23:0]        palette [16];

    // One movement step on one axis, clamped so the box stays on screen.
    function automatic logic [11:0] step_axis(input logic [11:0] p,
                                              input logic [1:0]  dir,
                                              input int          lim);
        int next;
        next = int'(p);
        case (dir)
            2'b01:   next = (int'(p) + STEP > lim) ? lim : int'(p) + STEP;
            2'b10:   next = (int'(p) >= STEP) ? int'(p) - STEP : 0;
            default: next = int'(p);
        endcase
        return 12'(next);
    endfunction

    // S1 address generation: offset of the scan point from the sprite origin,
    // box test, and texel address within the current animation frame.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        dx       = $signed({1'b0, lcd_xpos}) - $signed({1'b0, pos_x});
        dy       = $signed({1'b0, lcd_ypos}) - $signed({1'b0, pos_y});
        inside_c = enable && !dx[12] && !dy[12] &&
                   (int'(dx) < BOX_W) && (int'(dy) < BOX_H);
        tx       = dx[11:0] >> SCALE_LOG2;
        ty       = dy[11:0] >> SCALE_LOG2;
        addr_c   = 32'(anim_frame) * 32'(FRAME_TEXELS) +
                   32'(ty) * 32'(SPR_W) + 32'(tx);
    end

    // Frame tick fires on the first cycle the scan sits at (0,0).
    assign at_origin  = (lcd_xpos == 12'd0) && (lcd_ypos == 12'd0);
    assign frame_tick = at_origin && !origin_q;

    // S1/S2 registers: ROM address (held while outside the box) and the
    // coverage flag delayed to line up with the ROM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            rom_addr  <= '0;
            inside_s1 <= 1'b0;
            inside_s2 <= 1'b0;
            origin_q  <= 1'b0;
        end else begin
            inside_s1 <= inside_c;
            inside_s2 <= inside_s1;
            origin_q  <= at_origin;
            if (inside_c) begin
                rom_addr <= addr_c[ROM_AW-1:0];
            end
        end
    end

    // S3: palette lookup; index 0 is transparent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sprite_pixel <= '0;
            pixel_valid  <= 1'b0;
        end else if (inside_s2 && (rom_data != 4'd0)) begin
            sprite_pixel <= palette[rom_data];
            pixel_valid  <= 1'b1;
        end else begin
            sprite_pixel <= '0;
            pixel_valid  <= 1'b0;
        end
    end

    // Palette storage; a same-cycle read of the written entry sees the old colour.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the palette is small and must come up black, so it is built
        // from resettable flops rather than a RAM that cannot be cleared.
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= '0;
            end
        end else if (pal_we && (pal_addr != 4'd0)) begin
            palette[pal_addr] <= pal_wdata;
        end
    end

    // Movement and animation, advanced only on frame ticks so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_cnt   <= '0;
            anim_cnt   <= '0;
            pos_x      <= 12'(FIG_X0);
            pos_y      <= 12'(FIG_Y0);
            anim_frame <= '0;
        end else if (!enable) begin
            move_cnt <= '0;
            anim_cnt <= '0;
        end else if (!freeze && frame_tick) begin
            if (move_cnt == MCW'(MOVE_DIV - 1)) begin
                move_cnt <= '0;
                pos_x    <= step_axis(pos_x, mov_x, X_LIM);
                pos_y    <= step_axis(pos_y, mov_y, Y_LIM);
            end else begin
                move_cnt <= move_cnt + MCW'(1);
            end
            if (anim_cnt == ACW'(ANIM_DIV - 1)) begin
                anim_cnt   <= '0;
                anim_frame <= (anim_frame == AFW'(NUM_FRAMES - 1)) ?
                              '0 : anim_frame + AFW'(1);
            end else begin
                anim_cnt <= anim_cnt + ACW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sprite_pixel_gen.sv
// Bench for sprite_pixel_gen: directed scenarios plus randomized scans,
// all compared against a coordinate-level model of the sprite.
module tb_sprite_pixel_gen;

    localparam int X_MAX = 800, Y_MAX = 480;
    localparam int FIG_X0 = 730, FIG_Y0 = 220;
    localparam int SPR_W = 32, SPR_H = 20, SCALE = 2;
    localparam int NUM_FRAMES = 2, MOVE_DIV = 4, ANIM_DIV = 16, STEP = 1;
    localparam int BOX_W = SPR_W * SCALE, BOX_H = SPR_H * SCALE;
    localparam int X_LIM = X_MAX - BOX_W, Y_LIM = Y_MAX - BOX_H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] lcd_xpos = '0, lcd_ypos = '0;
    logic        enable = 1'b1, freeze = 1'b0;
    logic [1:0]  mov_x = 2'b00, mov_y = 2'b00;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = '0;
    logic [23:0] pal_wdata = '0;
    logic [10:0] rom_addr;
    logic [3:0]  rom_data = '0;
    logic [23:0] sprite_pixel;
    logic        pixel_valid;
    logic [11:0] pos_x, pos_y;
    logic [0:0]  anim_frame;

    int errors = 0;
    int checks = 0;

    sprite_pixel_gen dut (
        .clk(clk), .rst_n(rst_n), .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos),
        .enable(enable), .freeze(freeze), .mov_x(mov_x), .mov_y(mov_y),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .sprite_pixel(sprite_pixel), .pixel_valid(pixel_valid),
        .pos_x(pos_x), .pos_y(pos_y), .anim_frame(anim_frame)
    );

    always #5 clk = ~clk;

    // External synchronous sprite ROM: data one cycle after the address.
    logic [3:0] rom [2048];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Reference model: sprite position, frame, divider phases, palette, and
    // the texel index expected for the scan points still in flight.
    int          m_px, m_py, m_frame, m_mcnt, m_acnt;
    logic [23:0] m_pal [16];
    bit          m_prev_org;
    bit          s_in [2];
    logic [3:0]  s_idx [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_px = FIG_X0; m_py = FIG_Y0; m_frame = 0; m_mcnt = 0; m_acnt = 0;
        m_prev_org = 0;
        for (int i = 0; i < 16; i++) m_pal[i] = '0;
        for (int i = 0; i < 2; i++) begin s_in[i] = 0; s_idx[i] = '0; end
    endtask

    function automatic int move_axis(input int p, input logic [1:0] dir, input int lim);
        if (dir == 2'b01) return (p + STEP > lim) ? lim : p + STEP;
        if (dir == 2'b10) return (p >= STEP) ? p - STEP : 0;
        return p;
    endfunction

    // One clock: present a scan point (and optional palette write), advance
    // the model over the edge, then compare everything observable.
    task automatic cycle(input int x, input int y, input bit pw = 0,
                         input int pa = 0, input logic [23:0] pd = '0);
        int dx, dy, naddr;
        bit nin, tick, e_valid;
        logic [3:0] nidx;
        logic [23:0] e_pix;
        lcd_xpos = 12'(x); lcd_ypos = 12'(y);
        pal_we = pw; pal_addr = 4'(pa); pal_wdata = pd;
        dx = x - m_px; dy = y - m_py;
        nin = enable && dx >= 0 && dx < BOX_W && dy >= 0 && dy < BOX_H;
        naddr = m_frame * SPR_W * SPR_H + (dy / SCALE) * SPR_W + dx / SCALE;
        nidx = nin ? rom[naddr] : 4'd0;
        tick = (x == 0 && y == 0) && !m_prev_org;
        m_prev_org = (x == 0 && y == 0);
        @(posedge clk);
        e_valid = s_in[1] && (s_idx[1] != 0);
        e_pix = e_valid ? m_pal[s_idx[1]] : 24'd0;
        s_in[1] = s_in[0]; s_idx[1] = s_idx[0];
        s_in[0] = nin;     s_idx[0] = nidx;
        if (pw && pa != 0) m_pal[pa] = pd;
        if (!enable) begin
            m_mcnt = 0; m_acnt = 0;
        end else if (!freeze && tick) begin
            m_mcnt = (m_mcnt + 1) % MOVE_DIV;
            if (m_mcnt == 0) begin
                m_px = move_axis(m_px, mov_x, X_LIM);
                m_py = move_axis(m_py, mov_y, Y_LIM);
            end
            m_acnt = (m_acnt + 1) % ANIM_DIV;
            if (m_acnt == 0) m_frame = (m_frame + 1) % NUM_FRAMES;
        end
        #1;
        pal_we = 1'b0;
        check("valid", 32'(pixel_valid), 32'(e_valid));
        check("pixel", 32'(sprite_pixel), 32'(e_pix));
        check("pos_x", 32'(pos_x), 32'(m_px));
        check("pos_y", 32'(pos_y), 32'(m_py));
        check("anim_frame", 32'(anim_frame), 32'(m_frame));
        if (nin) check("rom_addr", 32'(rom_addr), 32'(naddr));
    endtask

    task automatic tick_frame();
        cycle(0, 0);
        cycle(100, 100);
    endtask

    int sx, sy;

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 4'd0;
        for (int i = 0; i < 640; i++) rom[i] = 4'd1;
        rom[2 * SPR_W + 3] = 4'd0;
        for (int i = 640; i < 1280; i++) rom[i] = 4'($urandom_range(0, 15));
        model_reset();

        // Reset state.
        #12;
        check("rst_pixel", 32'(sprite_pixel), 32'd0);
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_pos_x", 32'(pos_x), 32'd730);
        check("rst_pos_y", 32'(pos_y), 32'd220);
        check("rst_frame", 32'(anim_frame), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Palette load.
        cycle(5, 5, 1, 1, 24'hFF0000);
        for (int i = 2; i < 16; i++) cycle(5, 5, 1, i, 24'($urandom));
        cycle(5, 5, 1, 0, 24'h123456);

        // Box edges and a transparent texel.
        cycle(730, 220);
        cycle(729, 220);
        cycle(794, 220);
        check("first_pixel", 32'(sprite_pixel), 32'hFF0000);
        check("first_valid", 32'(pixel_valid), 32'd1);
        cycle(736, 224);
        cycle(737, 225);
        cycle(738, 224);
        cycle(736, 226);
        repeat (3) cycle(5, 5);

        // Palette written in the same cycle its entry is read.
        cycle(730, 220);
        cycle(731, 220);
        cycle(732, 220, 1, 1, 24'h00FF00);
        check("pal_old", 32'(sprite_pixel), 32'hFF0000);
        cycle(733, 220);
        check("pal_new", 32'(sprite_pixel), 32'h00FF00);
        repeat (3) cycle(5, 5);

        // +X movement with clamp; animation toggles every 16 ticks.
        mov_x = 2'b01;
        repeat (30) tick_frame();
        check("clamp_x", 32'(pos_x), 32'd736);
        check("frame_after_30", 32'(anim_frame), 32'd1);
        mov_x = 2'b00;
        cycle(736, 220);
        check("frame1_rom_addr", 32'(rom_addr), 32'd640);
        repeat (3) cycle(740 + 0, 221);

        // Freeze holds position and frame.
        freeze = 1'b1; mov_y = 2'b01;
        repeat (40) tick_frame();
        check("freeze_pos_y", 32'(pos_y), 32'd220);
        check("freeze_frame", 32'(anim_frame), 32'd1);
        freeze = 1'b0;

        // (0,0) held for three cycles counts once.
        repeat (12) begin
            cycle(0, 0); cycle(0, 0); cycle(0, 0); cycle(50, 50);
        end
        check("held_origin_pos_y", 32'(pos_y), 32'd223);

        // Disabled: nothing drawn, position held, dividers restart.
        enable = 1'b0;
        repeat (10) begin tick_frame(); cycle(740, 225); end
        check("disabled_pos_y", 32'(pos_y), 32'd223);
        enable = 1'b1;
        repeat (3) tick_frame();
        check("restart_no_step", 32'(pos_y), 32'd223);
        tick_frame();
        check("restart_step", 32'(pos_y), 32'd224);

        // Clamp at the top-left corner.
        mov_x = 2'b10; mov_y = 2'b10;
        repeat (3000) tick_frame();
        check("clamp_x0", 32'(pos_x), 32'd0);
        check("clamp_y0", 32'(pos_y), 32'd0);
        mov_x = 2'b00; mov_y = 2'b00;

        // Randomized scans, moves, palette writes and control changes.
        for (int n = 0; n < 4000; n++) begin
            if (n % 50 == 0) begin
                mov_x = 2'($urandom); mov_y = 2'($urandom);
                freeze = ($urandom_range(0, 9) == 0);
                enable = ($urandom_range(0, 7) != 0);
            end
            if ($urandom_range(0, 19) == 0) begin
                sx = 0; sy = 0;
            end else begin
                sx = m_px + int'($urandom_range(0, BOX_W + 16)) - 8;
                sy = m_py + int'($urandom_range(0, BOX_H + 16)) - 8;
                if (sx < 0) sx = 0;
                if (sx > X_MAX - 1) sx = X_MAX - 1;
                if (sy < 0) sy = 0;
                if (sy > Y_MAX - 1) sy = Y_MAX - 1;
            end
            if ($urandom_range(0, 19) == 0)
                cycle(sx, sy, 1, int'($urandom_range(0, 15)), 24'($urandom));
            else
                cycle(sx, sy);
        end
        enable = 1'b1; freeze = 1'b0; mov_x = 2'b00; mov_y = 2'b00;

        // Asynchronous reset in the middle of a sprite row.
        cycle(m_px + 2, m_py + 2);
        cycle(m_px + 3, m_py + 2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_pixel", 32'(sprite_pixel), 32'd0);
        check("arst_valid", 32'(pixel_valid), 32'd0);
        check("arst_rom_addr", 32'(rom_addr), 32'd0);
        check("arst_pos_x", 32'(pos_x), 32'd730);
        check("arst_pos_y", 32'(pos_y), 32'd220);
        check("arst_frame", 32'(anim_frame), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle(730 + i, 220);
        repeat (3) cycle(5, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
